// File: rtl/op_pkg.sv
// Shared definitions for the op pipeline stages: default widths, a constant
// clog2 helper and the common frame-FSM state encoding.
package op_pkg;

  // Width of the sum produced by the second-stage adder.
  localparam int unsigned IN_W_DFLT = 16;

  // Frame FSM states, shared so sibling stages encode their FSMs identically.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LAST  = 2'd2
  } op_state_e;

  // Ceiling log2, usable in parameter expressions.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    int unsigned rem;
    res = 0;
    rem = (value > 0) ? value - 1 : 0;
    while (rem > 0) begin
      res = res + 1;
      rem = rem >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/op3_satshift.sv
// Right-shift an accumulator total and saturate it into a narrower result.
// Ports:
//   total   in  ACC_W  unsigned value to scale
//   data_c  out OUT_W  total >> SHIFT, clipped to all ones on overflow
//   sat_c   out 1      set when data_c was clipped
module op3_satshift #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned SHIFT = 4,
  parameter int unsigned OUT_W = 16
) (
  input  logic [ACC_W-1:0] total,
  output logic [OUT_W-1:0] data_c,
  output logic             sat_c
);

  logic [ACC_W-1:0] shifted;

  assign shifted = total >> SHIFT;
  // Any bit above the result width means the value does not fit.
  assign sat_c   = (shifted >> OUT_W) != '0;
  assign data_c  = sat_c ? '1 : shifted[OUT_W-1:0];

endmodule

// File: rtl/op3_accum.sv
// Third pipeline stage: accumulates N sums per frame, then presents the
// shifted/saturated frame total through a one-entry valid/ready register.
// Ports:
//   clock, reset          rising-edge clock, async active-low reset
//   clear                 synchronous frame abort (pending output kept)
//   in_valid/in_ready     input handshake, data_in = unsigned sum
//   out_valid/out_ready   output handshake for data_out/sat_out
//   frame_cnt             samples accepted in the current frame
module op3_accum
  import op_pkg::*;
#(
  parameter  int unsigned IN_W  = IN_W_DFLT,
  parameter  int unsigned N     = 16,
  parameter  int unsigned ACC_W = 24,
  parameter  int unsigned SHIFT = 4,
  parameter  int unsigned OUT_W = 16,
  localparam int unsigned CNT_W = clog2(N)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [IN_W-1:0]  data_in,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] data_out,
  output logic             sat_out,
  output logic [CNT_W-1:0] frame_cnt
);

  // Parameter sanity checks at elaboration.
  if (N < 2) begin : g_bad_n
    $error("op3_accum: N must be >= 2");
  end
  if (ACC_W < IN_W + clog2(N)) begin : g_bad_acc
    $error("op3_accum: ACC_W too small for N sums of IN_W bits");
  end
  if (OUT_W + SHIFT > ACC_W) begin : g_bad_out
    $error("op3_accum: OUT_W exceeds ACC_W - SHIFT");
  end

  op_state_e        state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             valid_d;
  logic [OUT_W-1:0] data_d;
  logic             sat_d;

  logic [ACC_W-1:0] total_c;
  logic [CNT_W-1:0] cnt_inc_c;
  logic [OUT_W-1:0] scaled_c;
  logic             scaled_sat_c;

  // acc is zero in IDLE, so the same sum serves every state.
  assign total_c   = acc_q + ACC_W'(data_in);
  assign cnt_inc_c = cnt_q + CNT_W'(1);

  op3_satshift #(
    .ACC_W (ACC_W),
    .SHIFT (SHIFT),
    .OUT_W (OUT_W)
  ) u_satshift (
    .total  (total_c),
    .data_c (scaled_c),
    .sat_c  (scaled_sat_c)
  );

  // Stall only the completing sample, and only while the result slot is busy.
  assign in_ready  = !(state_q == LAST && out_valid && !out_ready);
  assign frame_cnt = cnt_q;

  // Next-state logic for the frame FSM and output register.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    valid_d = out_valid;
    data_d  = data_out;
    sat_d   = sat_out;

    if (out_valid && out_ready) begin
      valid_d = 1'b0;
    end

    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (in_valid && in_ready) begin
      case (state_q)
        LAST: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b1;
          data_d  = scaled_c;
          sat_d   = scaled_sat_c;
        end
        default: begin
          acc_d   = total_c;
          cnt_d   = cnt_inc_c;
          state_d = (cnt_inc_c == CNT_W'(N - 1)) ? LAST : ACCUM;
        end
      endcase
    end
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      out_valid <= 1'b0;
      data_out  <= '0;
      sat_out   <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      out_valid <= valid_d;
      data_out  <= data_d;
      sat_out   <= sat_d;
    end
  end

endmodule

// File: tb/tb_op3_accum.sv
// Self-checking bench for op3_accum: directed scenarios plus a random phase,
// checked every cycle against a frame-sum reference model.
module tb_op3_accum;

  localparam int N = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        clear;
  logic        in_valid;
  logic [15:0] data_in;
  logic        out_ready;

  logic        in_ready,  out_valid,  sat_out;
  logic [15:0] data_out;
  logic [3:0]  frame_cnt;
  logic        in_ready3, out_valid3, sat_out3;
  logic [15:0] data_out3;
  logic [3:0]  frame_cnt3;

  op3_accum u_dut (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .data_out  (data_out),
    .sat_out   (sat_out),
    .frame_cnt (frame_cnt)
  );

  op3_accum #(.SHIFT(3)) u_dut3 (
    .clock     (clock),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .data_in   (data_in),
    .in_ready  (in_ready3),
    .out_valid (out_valid3),
    .out_ready (out_ready),
    .data_out  (data_out3),
    .sat_out   (sat_out3),
    .frame_cnt (frame_cnt3)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Reference model: running frame sum, sample count and pending result.
  int          m_sum;
  int          m_cnt;
  logic        m_valid;
  logic [15:0] m_data, m_data3;
  logic        m_sat, m_sat3;
  logic        last_acc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Scale a frame total: {sat, value}.
  function automatic logic [16:0] scale(input int total, input int sh);
    int s;
    s = total >> sh;
    if (s > 65535) return {1'b1, 16'hFFFF};
    return {1'b0, 16'(s)};
  endfunction

  task automatic model_reset();
    m_sum = 0; m_cnt = 0; m_valid = 1'b0;
    m_data = '0; m_data3 = '0; m_sat = 1'b0; m_sat3 = 1'b0;
  endtask

  task automatic check_outputs();
    chk("out_valid", out_valid, m_valid);
    chk("data_out", data_out, m_data);
    chk("sat_out", sat_out, m_sat);
    chk("frame_cnt", frame_cnt, m_cnt);
    chk("out_valid3", out_valid3, m_valid);
    chk("data_out3", data_out3, m_data3);
    chk("sat_out3", sat_out3, m_sat3);
    chk("frame_cnt3", frame_cnt3, m_cnt);
  endtask

  // One clock: check in_ready, advance the model, check registered outputs.
  task automatic cycle();
    logic        exp_ready, hs, done;
    logic [16:0] r;
    #1;
    exp_ready = !(m_cnt == N - 1 && m_valid && !out_ready);
    chk("in_ready", in_ready, exp_ready);
    chk("in_ready3", in_ready3, exp_ready);
    last_acc = in_valid && exp_ready && !clear;
    hs   = m_valid && out_ready;
    done = 1'b0;
    if (clear) begin
      m_sum = 0; m_cnt = 0;
    end else if (last_acc) begin
      m_sum += int'(data_in);
      if (m_cnt == N - 1) begin
        done = 1'b1;
        r = scale(m_sum, 4); m_data  = r[15:0]; m_sat  = r[16];
        r = scale(m_sum, 3); m_data3 = r[15:0]; m_sat3 = r[16];
        m_sum = 0; m_cnt = 0;
      end else begin
        m_cnt++;
      end
    end
    if (done) m_valid = 1'b1;
    else if (hs) m_valid = 1'b0;
    @(posedge clock); #1;
    check_outputs();
  endtask

  // Present v until accepted (bounded).
  task automatic send(input logic [15:0] v);
    in_valid = 1'b1;
    data_in  = v;
    last_acc = 1'b0;
    for (int k = 0; k < 200; k++) begin
      cycle();
      if (last_acc) break;
    end
    if (!last_acc) begin
      tests++; fails++;
      $error("FAIL send_timeout: observed no accept expected accept of 0x%0h", v);
    end
    in_valid = 1'b0;
    data_in  = $urandom();
  endtask

  initial begin
    int idx;
    reset = 1'b0; clear = 1'b0; in_valid = 1'b0; data_in = '0; out_ready = 1'b1;
    model_reset();
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_sat_out", sat_out, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
    @(posedge clock); #1;
    reset = 1'b1;

    // Plain frame of 100s.
    for (int i = 0; i < N; i++) send(16'd100);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", data_out, 100);
    chk("t1_data3", data_out3, 200);
    cycle();
    chk("t1_drop", out_valid, 0);

    // Full-scale inputs: fits at SHIFT=4, clips at SHIFT=3.
    for (int i = 0; i < N; i++) send(16'hFFFF);
    chk("t2_data", data_out, 16'hFFFF);
    chk("t2_sat", sat_out, 0);
    chk("t2_data3", data_out3, 16'hFFFF);
    chk("t2_sat3", sat_out3, 1);
    cycle();

    // Backpressure across two frames.
    out_ready = 1'b0;
    for (int i = 0; i < 2 * N - 1; i++) send(16'd1);
    in_valid = 1'b1; data_in = 16'd1;
    for (int i = 0; i < 3; i++) cycle();
    chk("t3_stall_ready", in_ready, 0);
    chk("t3_stall_cnt", frame_cnt, 15);
    chk("t3_held_data", data_out, 1);
    out_ready = 1'b1;
    cycle();
    chk("t3_reload_valid", out_valid, 1);
    chk("t3_reload_cnt", frame_cnt, 0);
    in_valid = 1'b0;
    cycle();

    // Gappy input, values 0..15.
    idx = 0;
    for (int k = 0; k < 400 && idx < N; k++) begin
      in_valid = 1'($urandom_range(0, 1));
      data_in  = in_valid ? 16'(idx) : 16'($urandom());
      cycle();
      if (last_acc) idx++;
    end
    in_valid = 1'b0;
    chk("t4_accepts", idx, N);
    chk("t4_data", data_out, 7);
    chk("t4_valid", out_valid, 1);
    cycle();

    // Clear mid-frame with a pending result.
    out_ready = 1'b0;
    for (int i = 0; i < N; i++) send(16'd50);
    for (int i = 0; i < 5; i++) send(16'd1000);
    in_valid = 1'b1; data_in = 16'd9999; clear = 1'b1;
    cycle();
    clear = 1'b0; in_valid = 1'b0;
    chk("t5_clear_cnt", frame_cnt, 0);
    chk("t5_pend_valid", out_valid, 1);
    chk("t5_pend_data", data_out, 50);
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(16'd32);
    chk("t5_data", data_out, 32);
    cycle();

    // Asynchronous reset between clock edges.
    out_ready = 1'b0;
    for (int i = 0; i < N + 3; i++) send(16'd7);
    #3 reset = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_data", data_out, 0);
    chk("t6_rst_cnt", frame_cnt, 0);
    model_reset();
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) send(16'd16);
    chk("t6_data", data_out, 16);

    // Random traffic.
    for (int k = 0; k < 400; k++) begin
      in_valid  = 1'($urandom_range(0, 3) != 0);
      data_in   = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom());
      out_ready = 1'($urandom_range(0, 9) < 7);
      clear     = ($urandom_range(0, 31) == 0);
      cycle();
    end
    clear = 1'b0; in_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
